// File: rtl/rr_arb_resp_router.sv
// Round-robin N-to-1 request arbiter with an in-order ID FIFO that routes
// returning responses back to the initiator that issued each request.
module rr_arb_resp_router #(
  parameter int unsigned N_INIT          = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned RDATA_WIDTH     = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ID_WIDTH        = $clog2(N_INIT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_INIT-1:0]            data_req_i,
  input  logic [N_INIT*DATA_WIDTH-1:0] data_wdata_i,
  output logic [N_INIT-1:0]            data_gnt_o,
  output logic                         data_req_o,
  output logic [DATA_WIDTH-1:0]        data_wdata_o,
  output logic [ID_WIDTH-1:0]          data_ID_o,
  input  logic                         data_gnt_i,
  input  logic                         data_r_valid_i,
  input  logic [RDATA_WIDTH-1:0]       data_r_rdata_i,
  output logic [N_INIT-1:0]            data_r_valid_o,
  output logic [RDATA_WIDTH-1:0]       data_r_rdata_o,
  output logic                         resp_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [ID_WIDTH-1:0] rr_flag;
  logic [ID_WIDTH-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [ID_WIDTH-1:0] winner;
  logic [ID_WIDTH-1:0] head;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  // Winner search starts at rr_flag and wraps through all initiators.
  always_comb begin
    int unsigned         idx;
    logic [ID_WIDTH-1:0] cand;
    logic                found;
    winner = rr_flag;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int unsigned i = 0; i < N_INIT; i++) begin
      idx = 32'(rr_flag) + i;
      if (idx >= N_INIT) idx = idx - N_INIT;
      cand = ID_WIDTH'(idx);
      if (!found && data_req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    data_wdata_o = '0;
    for (int unsigned k = 0; k < N_INIT; k++) begin
      if (ID_WIDTH'(k) == winner) data_wdata_o = data_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign full           = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty          = (count == '0);
  assign data_ID_o      = winner;
  assign data_req_o     = (|data_req_i) & ~full;
  assign push           = data_req_o & data_gnt_i;
  assign data_gnt_o     = push ? (N_INIT'(1) << winner) : '0;
  assign head           = fifo_mem[rd_ptr];
  assign pop            = data_r_valid_i & ~empty;
  assign data_r_valid_o = pop ? (N_INIT'(1) << head) : '0;
  assign data_r_rdata_o = data_r_rdata_i;

  // ID storage needs no reset: entries are only read while count covers them.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= winner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_flag    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      resp_err_o <= 1'b0;
    end else begin
      if (push) begin
        rr_flag <= (rr_flag == ID_WIDTH'(N_INIT - 1)) ? '0 : rr_flag + ID_WIDTH'(1);
        wr_ptr  <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (data_r_valid_i && empty) resp_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_arb_resp_router.sv
// Randomised and directed bench for rr_arb_resp_router against a queue-based model.
module tb_rr_arb_resp_router;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 32;
  localparam int unsigned MO = 4;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]  gnt_o;
  logic          req_o;
  logic [DW-1:0] wdata_o;
  logic [IW-1:0] id_o;
  logic          gnt_i;
  logic          rv_i;
  logic [RW-1:0] rdata_i;
  logic [N-1:0]  rv_o;
  logic [RW-1:0] rdata_o;
  logic          err_o;

  rr_arb_resp_router #(.N_INIT(N), .DATA_WIDTH(DW), .RDATA_WIDTH(RW),
                       .MAX_OUTSTANDING(MO), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .data_req_i(req), .data_wdata_i(wdata),
    .data_gnt_o(gnt_o), .data_req_o(req_o), .data_wdata_o(wdata_o),
    .data_ID_o(id_o), .data_gnt_i(gnt_i), .data_r_valid_i(rv_i),
    .data_r_rdata_i(rdata_i), .data_r_valid_o(rv_o), .data_r_rdata_o(rdata_o),
    .resp_err_o(err_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: outstanding initiator IDs in issue order, pointer, sticky error.
  int q[$];
  int rr;
  bit err;
  logic [N-1:0]  e_gnt, e_rv;
  logic          e_req;
  int            e_w;
  logic [DW-1:0] e_wdata;

  function automatic void model_eval();
    int k;
    e_w = -1;
    for (int i = 0; i < N; i++) begin
      k = (rr + i) % N;
      if (e_w < 0 && req[k]) e_w = k;
    end
    e_req   = (req != '0) && (q.size() < MO);
    e_gnt   = (e_req && gnt_i) ? (4'(1) << e_w) : 4'(0);
    e_rv    = (rv_i && q.size() > 0) ? (4'(1) << q[0]) : 4'(0);
    e_wdata = (e_w >= 0) ? wdata[e_w*DW +: DW] : '0;
  endfunction

  function automatic void model_commit();
    bit push;
    bit pop;
    push = e_req && gnt_i;
    pop  = rv_i && q.size() > 0;
    if (rv_i && q.size() == 0) err = 1'b1;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(e_w);
      rr = (rr + 1) % N;
    end
  endfunction

  task automatic apply(input logic [N-1:0] r, input logic g, input logic v);
    @(negedge clk);
    req = r; gnt_i = g; rv_i = v; rdata_i = $urandom;
    for (int k = 0; k < N; k++) wdata[k*DW +: DW] = $urandom;
    #1;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; gnt_i = 1'b0; rv_i = 1'b0; rdata_i = '0; wdata = '0;
    q.delete(); rr = 0; err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; gnt_i = 1'b0; rv_i = 1'b0; rdata_i = '0; wdata = '0;
    q.delete(); rr = 0; err = 1'b0;
    #1;
    vectors++;
    if (gnt_o !== 4'b0 || req_o !== 1'b0 || rv_o !== 4'b0 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs gnt=%b req=%b rv=%b err=%b, want all zero", gnt_o, req_o, rv_o, err_o);
    end
    vectors++;
    if (dut.rr_flag !== 2'd0 || dut.count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_state rr=%0d count=%0d, want 0/0", dut.rr_flag, dut.count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rr_continuous();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      apply((c < 8) ? 4'hF : 4'h0, c < 8, c > 0);
      vectors++;
      if (gnt_o !== ((c < 8) ? (4'(1) << (c % 4)) : 4'(0)) || gnt_o !== e_gnt) begin
        miscompares++;
        $display("FAIL rr_gnt cyc%0d got %b want %b", c, gnt_o, e_gnt);
      end
      vectors++;
      if (rv_o !== ((c > 0) ? (4'(1) << ((c - 1) % 4)) : 4'(0)) || rv_o !== e_rv) begin
        miscompares++;
        $display("FAIL rr_rvalid cyc%0d got %b want %b", c, rv_o, e_rv);
      end
      vectors++;
      if (c < 8 && (id_o !== IW'(e_w) || wdata_o !== e_wdata)) begin
        miscompares++;
        $display("FAIL rr_payload cyc%0d id=%0d want %0d wdata=%h want %h", c, id_o, e_w, wdata_o, e_wdata);
      end
      advance();
    end
    #1;
    vectors++;
    if (dut.rr_flag !== 2'd0 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_wrap rr=%0d err=%b want 0/0", dut.rr_flag, err_o);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      apply(4'b0100, 1'b1, 1'b0);
      vectors++;
      if (gnt_o !== ((c < 4) ? 4'b0100 : 4'b0000) || req_o !== (c < 4) || gnt_o !== e_gnt) begin
        miscompares++;
        $display("FAIL full_fill cyc%0d gnt=%b req=%b want %b/%b", c, gnt_o, req_o, e_gnt, e_req);
      end
      advance();
    end
    apply(4'b0100, 1'b1, 1'b1);
    vectors++;
    if (rv_o !== 4'b0100 || gnt_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL full_pop rv=%b gnt=%b want 0100/0000", rv_o, gnt_o);
    end
    advance();
    apply(4'b0100, 1'b1, 1'b0);
    vectors++;
    if (gnt_o !== 4'b0100) begin
      miscompares++;
      $display("FAIL full_regrant gnt=%b want 0100", gnt_o);
    end
    advance();
    for (int c = 0; c < 5; c++) begin
      apply(4'b0000, 1'b0, 1'b1);
      vectors++;
      if (rv_o !== ((c < 4) ? 4'b0100 : 4'b0000) || rv_o !== e_rv) begin
        miscompares++;
        $display("FAIL full_drain cyc%0d rv=%b want %b", c, rv_o, e_rv);
      end
      advance();
    end
  endtask

  task automatic test_hold();
    do_reset();
    repeat (2) begin apply(4'hF, 1'b1, 1'b0); advance(); end
    repeat (2) begin apply(4'h0, 1'b0, 1'b1); advance(); end
    for (int c = 0; c < 3; c++) begin
      apply(4'b1010, 1'b0, 1'b0);
      vectors++;
      if (id_o !== 2'd3 || gnt_o !== 4'b0 || req_o !== 1'b1 || dut.rr_flag !== 2'd2) begin
        miscompares++;
        $display("FAIL hold cyc%0d id=%0d gnt=%b req=%b rr=%0d want 3/0000/1/2", c, id_o, gnt_o, req_o, dut.rr_flag);
      end
      advance();
    end
    apply(4'b1010, 1'b1, 1'b0);
    vectors++;
    if (gnt_o !== 4'b1000 || wdata_o !== wdata[3*DW +: DW]) begin
      miscompares++;
      $display("FAIL hold_grant gnt=%b want 1000 wdata=%h want %h", gnt_o, wdata_o, wdata[3*DW +: DW]);
    end
    advance();
    #1;
    vectors++;
    if (dut.rr_flag !== 2'd3) begin
      miscompares++;
      $display("FAIL hold_rr rr=%0d want 3", dut.rr_flag);
    end
    apply(4'h0, 1'b0, 1'b1);
    advance();
  endtask

  task automatic test_push_pop();
    do_reset();
    repeat (2) begin apply(4'hF, 1'b1, 1'b0); advance(); end
    apply(4'hF, 1'b1, 1'b1);
    vectors++;
    if (gnt_o !== 4'b0100 || rv_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL pushpop gnt=%b rv=%b want 0100/0001", gnt_o, rv_o);
    end
    advance();
    #1;
    vectors++;
    if (dut.count !== 3'd2) begin
      miscompares++;
      $display("FAIL pushpop_count count=%0d want 2", dut.count);
    end
    for (int c = 0; c < 2; c++) begin
      apply(4'h0, 1'b0, 1'b1);
      vectors++;
      if (rv_o !== ((c == 0) ? 4'b0010 : 4'b0100) || rv_o !== e_rv) begin
        miscompares++;
        $display("FAIL pushpop_order cyc%0d rv=%b want %b", c, rv_o, e_rv);
      end
      advance();
    end
  endtask

  task automatic test_empty_err();
    do_reset();
    apply(4'h0, 1'b0, 1'b1);
    vectors++;
    if (rv_o !== 4'b0 || err_o !== 1'b0 || rdata_o !== rdata_i) begin
      miscompares++;
      $display("FAIL empty_resp rv=%b err=%b rdata=%h want 0000/0/%h", rv_o, err_o, rdata_o, rdata_i);
    end
    advance();
    for (int c = 0; c < 4; c++) begin
      apply(4'hF, 1'b1, c > 0);
      vectors++;
      if (err_o !== 1'b1 || rv_o !== e_rv || gnt_o !== e_gnt) begin
        miscompares++;
        $display("FAIL err_sticky cyc%0d err=%b rv=%b gnt=%b want 1/%b/%b", c, err_o, rv_o, gnt_o, e_rv, e_gnt);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) begin apply(4'hF, 1'b1, 1'b0); advance(); end
    @(negedge clk);
    req = '0; gnt_i = 1'b0; rv_i = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete(); rr = 0; err = 1'b0;
    vectors++;
    if (dut.count !== 3'd0 || dut.rr_flag !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_mid count=%0d rr=%0d want 0/0", dut.count, dut.rr_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'h0, 1'b0, 1'b1);
    vectors++;
    if (rv_o !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_mid_resp rv=%b want 0000", rv_o);
    end
    advance();
    apply(4'hF, 1'b1, 1'b0);
    vectors++;
    if (gnt_o !== 4'b0001 || err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_regrant gnt=%b err=%b want 0001/1", gnt_o, err_o);
    end
    advance();
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic g, v;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = N'($urandom);
      g = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 2) == 0);
      apply(r, g, v);
      vectors++;
      if (gnt_o !== e_gnt || req_o !== e_req || rv_o !== e_rv || err_o !== err ||
          rdata_o !== rdata_i || (e_w >= 0 && (id_o !== IW'(e_w) || wdata_o !== e_wdata))) begin
        miscompares++;
        $display("FAIL random cyc%0d gnt=%b/%b req=%b/%b id=%0d/%0d rv=%b/%b err=%b/%b",
                 c, gnt_o, e_gnt, req_o, e_req, id_o, e_w, rv_o, e_rv, err_o, err);
      end
      advance();
    end
  endtask

  initial begin
    rst_n = 1'b1; req = '0; gnt_i = 1'b0; rv_i = 1'b0; rdata_i = '0; wdata = '0;
    q.delete(); rr = 0; err = 1'b0;
    test_reset();
    test_rr_continuous();
    test_full();
    test_hold();
    test_push_pop();
    test_empty_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_arb_resp_router.md
Name: rr_arb_resp_router

Overview:
- N-to-1 round-robin request arbiter node for the low-latency interconnect, using grant-based flow control.
- Internally owns the round-robin pointer; the pointer advances only on an accepted request (req & gnt).
- Records the winning initiator of every accepted request in an in-order ID FIFO.
- Routes each returning response (r_valid) back to the initiator that issued it, so the block terminates both request and response legs of one target port.

Parameters:
- N_INIT, 4, number of initiator ports (>= 2).
- DATA_WIDTH, 32, request payload width per initiator (address/we/be/wdata packed by the caller).
- RDATA_WIDTH, 32, response data width.
- MAX_OUTSTANDING, 4, ID FIFO depth; maximum accepted-but-unanswered requests (>= 1).
- ID_WIDTH, $clog2(N_INIT), initiator index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- data_req_i  in  N_INIT  request per initiator.
- data_wdata_i  in  N_INIT*DATA_WIDTH  request payloads; initiator k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- data_gnt_o  out  N_INIT  one-hot-or-zero grant back to initiators.
- data_req_o  out  1  request toward target.
- data_wdata_o  out  DATA_WIDTH  payload of the arbitration winner.
- data_ID_o  out  ID_WIDTH  index of the winner.
- data_gnt_i  in  1  target grant.
- data_r_valid_i  in  1  response valid from target; in-order, single-cycle pulse per response.
- data_r_rdata_i  in  RDATA_WIDTH  response data.
- data_r_valid_o  out  N_INIT  one-hot response valid to the owning initiator.
- data_r_rdata_o  out  RDATA_WIDTH  response data, broadcast to all initiators.
- resp_err_o  out  1  sticky flag: response received with the ID FIFO empty.

Behaviour:
- Reset (async, rst_n=0):
  - rr_flag=0; FIFO empty, count=0, read/write pointers=0; resp_err_o=0.
  - Combinational outputs then follow inputs with an empty FIFO: data_r_valid_o=0, data_gnt_o=0 unless a request is granted.
- Arbitration (combinational):
  - Search order is rr_flag, rr_flag+1, …, N_INIT-1, 0, …, rr_flag-1.
  - Winner w = first index with data_req_i set.
  - data_ID_o=w; data_wdata_o=slice w. Both are don't-care when no request is present, but must be stable for a fixed input.
- Request/grant:
  - full = (count==MAX_OUTSTANDING), evaluated on the registered count.
  - data_req_o = |data_req_i & ~full.
  - data_gnt_o[w] = data_req_o & data_gnt_i; all other bits 0.
  - While full, no grant is issued even if a pop occurs in the same cycle.
- Handshake, when data_req_o & data_gnt_i:
  - Push w into the FIFO.
  - rr_flag <= (rr_flag==N_INIT-1) ? 0 : rr_flag+1.
  - rr_flag is otherwise held. Pointer steps by one per handshake, not to w+1.
- Response path (combinational from head):
  - When data_r_valid_i & ~empty: data_r_valid_o[head]=1 and the FIFO pops.
  - data_r_rdata_o = data_r_rdata_i at all times.
  - A response in the same cycle as the push of its own request is illegal; the FIFO has no fall-through, so the earliest legal response is one cycle after the grant.
- Empty response: data_r_valid_i with empty FIFO → data_r_valid_o=0, no pop, resp_err_o<=1. resp_err_o stays set until reset.
- Count update:
  - push only → +1; pop only → -1; push and pop together → unchanged.
  - FIFO pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-operation: all outstanding IDs are discarded and rr_flag returns to 0. Responses arriving afterwards set resp_err_o.

Test Plan:
- All four initiators request continuously, data_gnt_i=1, responses returned 1 cycle later → after 8 grants:
  - grant sequence is 0,1,2,3,0,1,2,3;
  - rr_flag back at 0;
  - data_r_valid_o one-hot pattern repeats the same sequence.
- Only initiator 2 requests, data_gnt_i=1, MAX_OUTSTANDING=4, no responses → exactly 4 grants, then data_req_o=0 and data_gnt_o=0. One r_valid pulse → data_r_valid_o=4'b0100, and a grant issues the following cycle.
- Requests from initiators 1 and 3, rr_flag=2, data_gnt_i=0 for 3 cycles → data_ID_o=3 throughout; data_gnt_o=0; rr_flag stays 2. Raise data_gnt_i → data_gnt_o=4'b1000; rr_flag becomes 3.
- Simultaneous push and pop with count=2 → count stays 2; FIFO ordering preserved; the next response goes to the oldest ID.
- data_r_valid_i pulse with FIFO empty → data_r_valid_o=0; resp_err_o rises next edge and stays 1 through further traffic.
- Assert rst_n=0 with 3 outstanding → count=0 and rr_flag=0 immediately. A subsequent response sets resp_err_o; new requests are granted starting at initiator 0.
